// File: rtl/spi_adc_scan_master.sv
// ---------------------------------------------------------------------------
// spi_adc_scan_master
//   Periodic/triggered scan master for a 2-channel 12-bit SPI ADC
//   (MCP3202-style frame: START, SGL, ODD, MSBF, null bit, D11..D0).
//   The ADC is polled once per slot of SAMPLE_PERIOD clk cycles. In
//   free-running mode every slot converts; in triggered mode a slot converts
//   only if a trigger is pending. Enabled channels are visited round-robin.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   i_EN              conversions permitted
//   i_ONESHOT         1 = triggered mode, 0 = free-running
//   i_TRIG            single-cycle conversion request (triggered mode)
//   i_CH_MASK[1:0]    channel enable mask, sampled at frame start
//   i_READY           consumer accepts o_DATA while DATA_VALID=1
//   MISO              ADC Dout
//   MOSI, SCK, CS     ADC Din, SPI clock (mode 0,0), active-low chip select
//   o_DATA[11:0]      last conversion result
//   o_CH              channel of o_DATA
//   DATA_VALID        o_DATA/o_CH valid
//   o_BUSY            frame in progress (CS low)
//   o_OVERRUN         sticky: a result was overwritten before being taken
// ---------------------------------------------------------------------------
module spi_adc_scan_master #(
  parameter int unsigned CLK_DIV       = 70,
  parameter int unsigned SAMPLE_PERIOD = 2500,
  parameter int unsigned TSUCS         = 56,
  parameter int unsigned TCSH          = 64,
  parameter bit          SGL           = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_EN,
  input  logic        i_ONESHOT,
  input  logic        i_TRIG,
  input  logic [1:0]  i_CH_MASK,
  input  logic        i_READY,
  input  logic        MISO,
  output logic        MOSI,
  output logic        SCK,
  output logic        CS,
  output logic [11:0] o_DATA,
  output logic        o_CH,
  output logic        DATA_VALID,
  output logic        o_BUSY,
  output logic        o_OVERRUN
);

  if (CLK_DIV < 2 || SAMPLE_PERIOD < TSUCS + 34 * CLK_DIV + TCSH) begin : g_param_check
    $error("spi_adc_scan_master: illegal timing parameters");
  end

  localparam int unsigned CW   = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TMAX = (TSUCS > 2 * CLK_DIV) ? TSUCS : 2 * CLK_DIV;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(TSUCS - 1);
  localparam logic [TW-1:0] HIGH_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] CYC_LAST   = TW'(2 * CLK_DIV - 1);
  localparam logic [4:0]    LAST_BIT   = 5'd17;
  localparam logic [4:0]    FIRST_DATA = 5'd6;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    bitn_q, bitn_d;
  logic          cs_q, cs_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic [11:0]   sreg_q, sreg_d;
  logic          ch_q, ch_d;
  logic          last_q, last_d;
  logic [11:0]   data_q, data_d;
  logic          och_q, och_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          pend_q, pend_d;

  logic          tick;
  logic          start_frame;
  logic          next_ch;
  logic [4:0]    nxt_bit;

  // armed_q masks the count-0 seen straight out of reset so the first frame
  // waits a full slot after rst_n releases.
  assign tick        = (cnt_q == '0) && armed_q;
  assign start_frame = tick && i_EN && (i_CH_MASK != 2'b00) && (!i_ONESHOT || pend_q);
  // Round-robin: prefer the other channel, fall back to the same one.
  assign next_ch     = i_CH_MASK[~last_q] ? ~last_q : last_q;
  assign nxt_bit     = bitn_q + 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    armed_d = armed_q | (cnt_q == CNT_LAST);
    tmr_d   = tmr_q + 1'b1;
    bitn_d  = bitn_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    sreg_d  = sreg_q;
    ch_d    = ch_q;
    last_d  = last_q;
    data_d  = data_q;
    och_d   = och_q;
    valid_d = valid_q & ~i_READY;
    ovr_d   = ovr_q;
    // Triggers only register while idle-side (CS high) and nothing pending.
    pend_d  = pend_q | (i_ONESHOT & i_TRIG & cs_q);

    case (state_q)
      IDLE, HOLD: begin
        // HOLD ends on the tick and is judged as IDLE in that same cycle,
        // so back-to-back slots keep exactly SAMPLE_PERIOD spacing.
        if (tick) begin
          state_d = IDLE;
          if (start_frame) begin
            state_d = SETUP;
            cs_d    = 1'b0;
            mosi_d  = 1'b1;
            tmr_d   = '0;
            pend_d  = 1'b0;
            ch_d    = next_ch;
            last_d  = next_ch;
          end
        end
      end
      SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = SHIFT;
          sck_d   = 1'b1;
          tmr_d   = '0;
          bitn_d  = 5'd1;
        end
      end
      SHIFT: begin
        if (tmr_q == HIGH_LAST) begin
          sck_d = 1'b0;
          case (nxt_bit)
            5'd2:    mosi_d = SGL;
            5'd3:    mosi_d = ch_q;
            5'd4:    mosi_d = 1'b1;
            default: mosi_d = 1'b0;
          endcase
        end else if (tmr_q == CYC_LAST) begin
          if (bitn_q == LAST_BIT) begin
            state_d = HOLD;
            cs_d    = 1'b1;
            data_d  = sreg_q;
            och_d   = ch_q;
            valid_d = 1'b1;
            ovr_d   = ovr_q | (valid_q & ~i_READY);
          end else begin
            sck_d  = 1'b1;
            tmr_d  = '0;
            bitn_d = nxt_bit;
            if (nxt_bit >= FIRST_DATA) begin
              sreg_d = {sreg_q[10:0], MISO};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      tmr_q   <= '0;
      bitn_q  <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sreg_q  <= '0;
      ch_q    <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
      och_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      tmr_q   <= tmr_d;
      bitn_q  <= bitn_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      sreg_q  <= sreg_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      data_q  <= data_d;
      och_q   <= och_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
    end
  end

  assign CS         = cs_q;
  assign SCK        = sck_q;
  assign MOSI       = mosi_q;
  assign o_DATA     = data_q;
  assign o_CH       = och_q;
  assign DATA_VALID = valid_q;
  assign o_BUSY     = ~cs_q;
  assign o_OVERRUN  = ovr_q;

endmodule

// File: doc/spi_adc_scan_master.md
SPI_ADC_SCAN_MASTER -- requirements
Module: spi_adc_scan_master

Interface
REQ-001 Parameter CLK_DIV, default 70: SCK half-period in clk cycles (SCK = clk/140, 893 kHz at 125 MHz); legal range >= 2.
REQ-002 Parameter SAMPLE_PERIOD, default 2500: clk cycles per conversion slot (50 kHz at 125 MHz).
REQ-003 Parameter TSUCS, default 56: clk cycles from CS falling to the first SCK rising edge.
REQ-004 Parameter TCSH, default 64: minimum clk cycles CS stays high between frames.
REQ-005 Parameter SGL, default 1: 1 = single-ended, 0 = pseudo-differential.
REQ-006 Parameter legality: SAMPLE_PERIOD >= TSUCS + 34*CLK_DIV + TCSH; the defaults meet this exactly.
REQ-007 clk  in  1  system clock, 125 MHz.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 i_EN  in  1  1 = conversions permitted.
REQ-010 i_ONESHOT  in  1  1 = triggered mode, 0 = free-running.
REQ-011 i_TRIG  in  1  single-cycle conversion request, used in triggered mode only.
REQ-012 i_CH_MASK  in  2  channel enable mask; bit n enables ADC channel n.
REQ-013 i_READY  in  1  consumer accepts o_DATA when DATA_VALID=1.
REQ-014 MISO  in  1  ADC Dout.
REQ-015 MOSI, SCK, CS  out  1 each  ADC Din, SPI clock, active-low chip select.
REQ-016 o_DATA  out  12  last conversion result.
REQ-017 o_CH  out  1  channel of o_DATA.
REQ-018 DATA_VALID  out  1  o_DATA/o_CH valid.
REQ-019 o_BUSY  out  1  1 while a frame is in progress (CS low).
REQ-020 o_OVERRUN  out  1  sticky flag: a result was lost.

Function
REQ-021 The slot counter SHALL count 0..SAMPLE_PERIOD-1 and wrap; the tick is count 0, and the counter runs regardless of i_EN.
REQ-022 The FSM SHALL have four states: IDLE, SETUP (CS low, waiting TSUCS), SHIFT (17 SCK cycles), and HOLD (CS high until the next tick).
REQ-023 IDLE->SETUP SHALL occur on a tick when i_EN=1 and i_CH_MASK!=0, and, in triggered mode, a trigger is pending; otherwise the FSM stays in IDLE.
REQ-024 In triggered mode, an i_TRIG pulse SHALL set the pending flag; starting a frame SHALL clear it; extra pulses while the flag is pending or a frame is busy SHALL be dropped.
REQ-025 Channel selection at frame start: the next enabled channel after the last one converted, round-robin; the first frame after reset uses the lowest enabled channel; i_CH_MASK SHALL be sampled only at frame start.
REQ-026 SCK SHALL idle low (mode 0,0); each SCK cycle is CLK_DIV clk cycles high followed by CLK_DIV clk cycles low.
REQ-027 MOSI bit order: START=1, SGL, ODD=channel, MSBF=1, then 0 for the remainder of the frame.
REQ-028 MOSI SHALL be driven with START in the same cycle CS falls, and SHALL update on each SCK falling edge.
REQ-029 SCK cycle 5 (null bit) SHALL be ignored; MISO SHALL be sampled on the clk edge where SCK rises in cycles 6..17, yielding D11..D0 MSB first.
REQ-030 At the end of the low half of SCK cycle 17, CS SHALL rise and o_BUSY SHALL fall; o_DATA, o_CH and DATA_VALID=1 SHALL update in that same cycle.
REQ-031 The CS-low duration SHALL be exactly TSUCS + 34*CLK_DIV clk cycles.
REQ-032 DATA_VALID SHALL hold until a cycle with i_READY=1, then clear the next cycle.
REQ-033 If a new result lands while DATA_VALID=1 and i_READY=0, the new result SHALL overwrite o_DATA/o_CH, DATA_VALID SHALL stay 1, and o_OVERRUN SHALL be set.
REQ-034 If i_READY=1 in the same cycle a new result lands, there is no overrun and DATA_VALID stays 1.
REQ-035 o_OVERRUN SHALL clear only on reset.
REQ-036 Deasserting i_EN mid-frame SHALL complete the current frame; no new frame starts afterwards.
REQ-037 HOLD SHALL return to IDLE on the next tick, evaluated as IDLE in that same cycle.

Reset
REQ-038 rst_n low SHALL asynchronously force: CS=1, SCK=0, MOSI=0, DATA_VALID=0, o_BUSY=0, o_OVERRUN=0, o_DATA=0, o_CH=0, FSM=IDLE, slot counter=0, trigger pending=0, round-robin pointer = channel 1.
REQ-039 Reset asserted mid-frame SHALL abort the frame immediately; no partial result is produced.
REQ-040 After rst_n deasserts, the first frame SHALL start at the first tick at least SAMPLE_PERIOD cycles later.

Verification
REQ-041 Defaults, free-running, mask=01, ADC model returns 0xA5C, i_READY=1: CS low exactly 2436 cycles, SCK 17 pulses of 70/70, MOSI 1,1,0,1, o_DATA=0xA5C, o_CH=0, one frame per 2500 cycles.
REQ-042 Mask=11, model returns 0x111 on ch0 and 0xEEE on ch1: results alternate ch0/ch1 with the correct data, and MOSI ODD bit alternates 0/1.
REQ-043 i_READY=0 across two frames: o_OVERRUN=1 after the second frame, and o_DATA holds the second value.
REQ-044 i_ONESHOT=1, three i_TRIG pulses within one slot: exactly one frame; no frames with no trigger.
REQ-045 rst_n pulsed low at SCK cycle 9: CS=1 and SCK=0 asynchronously, DATA_VALID stays 0, and normal operation resumes afterwards.
REQ-046 i_EN dropped during SETUP: that frame completes with a valid result, and no further CS falls.
